rvfi_reorder_buffer: RTL and testbench
======================================

// Module: rvfi_reorder_buffer
// PURPOSE
//  Upstream of the per-register consistency checker: collects RVFI retirements that arrive out of
//  program order across NRET channels and re-emits them as a single in-order channel (NRET=1 stream).
//  Slot index = rvfi_order mod DEPTH; drains strictly by ascending order, one record per cycle.
//  Out-of-window and duplicate orders raise sticky error flags.
// PARAMETERS
//  NRET     2   retirement channels in
//  XLEN     32  register width
//  ORDER_W  8   width of rvfi_order field (modular, wraps)
//  DEPTH    8   slots; power of 2, 2..2**ORDER_W
// PORTS
//  clk          in   1            clock
//  resetn       in   1            reset, synchronous, active-low
//  in_valid     in   NRET         per-channel retirement valid
//  in_rec       in   NRET*REC_W   per-channel packed record (order,insn,rs1/rs2/rd addr,pc,rdata,wdata,trap,mem)
//  out_valid    out  1            in-order record valid
//  out_rec      out  REC_W        in-order packed record
//  out_order    out  ORDER_W      order of out_rec (== expected counter at emit)
//  level        out  $clog2(DEPTH)+1  occupied slots
//  err_window   out  1            sticky: order outside [next, next+DEPTH-1]
//  err_dup      out  1            sticky: slot already occupied / two channels same order
// BEHAVIOUR
//  - Reset (resetn=0 at edge): all slot valid bits 0, next_order=0, out_valid=0, out_rec=0,
//    out_order=0, level=0, err_*=0. Reset mid-operation discards all buffered records.
//  - Write: per channel c with in_valid[c], o=order field; dist=(o-next_order) mod 2**ORDER_W,
//    next_order taken BEFORE the edge. dist>=DEPTH -> record dropped, err_window<=1.
//    Slot o%DEPTH already valid, or lower channel same cycle has same o -> dropped, err_dup<=1.
//    Otherwise slot written, slot valid<=1.
//  - Drain: if slot[next_order%DEPTH] valid (registered state) at edge: out_valid<=1,
//    out_rec<=slot, out_order<=next_order, slot valid<=0, next_order<=next_order+1 (wraps).
//    Else out_valid<=0. Output held only one cycle; no backpressure.
//  - Latency: record with order==next_order sampled at edge E -> out_valid high after edge E+1.
//    No input-to-output bypass.
//  - Same-edge write+drain of one slot impossible: that write has dist==DEPTH -> err_window.
//  - level = popcount of slot valid bits (registered, updated with writes/drain same edge).
//  - Errors sticky until reset; buffer continues operating after an error.
//  - Throughput: NRET in, 1 out per cycle; bursts absorbed up to DEPTH, excess -> err_window.
// CONFIGURATION
//  RVFI_REORDER_ASSERT_EN defined: formal immediate assert(!err_window && !err_dup) each clk
//   when resetn, plus assert(level<=DEPTH). Undefined: flags only, no assertions emitted.
// STRUCTURE
//  Shared package rvfi_reorder_pkg: REC_W, field offset/width localparams, pack/unpack functions
//   for the record; reused by checker-side unpackers.
//  One sub-module rvfi_reorder_slot: one storage entry (valid bit, REC_W data, write/clear ports),
//   instantiated DEPTH times; top holds next_order, window/dup logic, drain mux, level counter.
// TESTING (NRET=2, DEPTH=8, ORDER_W=8)
//  In-order: orders 0,1 on ch0,ch1 same cycle -> out 0 then 1 on consecutive cycles, level 2->1->0.
//  Reverse: order 3,2,1 then 0 one per cycle -> out 0,1,2,3 back-to-back after 0 arrives, no errors.
//  Wrap: preload next_order=254 via 254 in-order retirements; send 1,0,255,254 -> out 254,255,0,1.
//  Window: next_order=0, send order 8 -> dropped, err_window=1, level unchanged; order 7 accepted.
//  Dup: order 5 on ch0 and ch1 same cycle -> one stored, err_dup=1; out 5 appears once.
//  Reset: 4 records buffered, resetn=0 one cycle -> level=0, out_valid=0, errors 0, order 0 drains.

Source files
------------

// File: rtl/rvfi_reorder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rvfi_reorder_pkg
// Purpose  : RVFI retirement record layout shared by the reorder buffer and
//            the checker-side unpackers.
// Revision : 1.0
// ============================================================================
package rvfi_reorder_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int ORDER_W_DEF = 8;

  // Order sits in the MSBs so the buffer can extract it without unpacking.
  typedef struct packed {
    logic [ORDER_W_DEF-1:0] order;
    logic [31:0]            insn;
    logic [4:0]             rs1_addr;
    logic [4:0]             rs2_addr;
    logic [4:0]             rd_addr;
    logic [XLEN_DEF-1:0]    pc;
    logic [XLEN_DEF-1:0]    rdata;
    logic [XLEN_DEF-1:0]    wdata;
    logic                   trap;
    logic [XLEN_DEF-1:0]    mem_addr;
  } rvfi_rec_t;

  localparam int REC_W = $bits(rvfi_rec_t);

  localparam int MEM_LSB   = 0;
  localparam int TRAP_LSB  = XLEN_DEF;
  localparam int WDATA_LSB = XLEN_DEF + 1;
  localparam int RDATA_LSB = 2 * XLEN_DEF + 1;
  localparam int PC_LSB    = 3 * XLEN_DEF + 1;
  localparam int RD_LSB    = 4 * XLEN_DEF + 1;
  localparam int RS2_LSB   = RD_LSB + 5;
  localparam int RS1_LSB   = RS2_LSB + 5;
  localparam int INSN_LSB  = RS1_LSB + 5;
  localparam int ORDER_LSB = INSN_LSB + 32;

  function automatic int rec_width(input int xlen, input int order_w);
    return order_w + 32 + 15 + 4 * xlen + 1;
  endfunction

  function automatic logic [REC_W-1:0] rec_pack(input rvfi_rec_t r);
    return r;
  endfunction

  function automatic rvfi_rec_t rec_unpack(input logic [REC_W-1:0] v);
    return rvfi_rec_t'(v);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rvfi_reorder_slot.sv
`default_nettype none
// ============================================================================
// Module   : rvfi_reorder_slot
// Purpose  : One reorder-buffer entry: valid bit plus record storage.
// Revision : 1.0
// ============================================================================
module rvfi_reorder_slot #(
  parameter int REC_W = 184
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_en,
  input  logic [REC_W-1:0] wr_data,
  input  logic             clr,
  output logic             valid,
  output logic [REC_W-1:0] data
);

  logic             r_valid;
  logic [REC_W-1:0] r_data;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (clr)
        r_valid <= 1'b0;
      if (wr_en) begin
        r_valid <= 1'b1;
        r_data  <= wr_data;
      end
    end
  end

  assign valid = r_valid;
  assign data  = r_data;

endmodule
`default_nettype wire

// File: rtl/rvfi_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module   : rvfi_reorder_buffer
// Purpose  : Re-sequences out-of-order RVFI retirements from NRET channels
//            into one in-order stream. Define RVFI_REORDER_ASSERT_EN to emit
//            immediate assertions on the error flags and level bound.
// Revision : 1.0
// ============================================================================
module rvfi_reorder_buffer
  import rvfi_reorder_pkg::*;
#(
  parameter int NRET    = 2,
  parameter int XLEN    = XLEN_DEF,
  parameter int ORDER_W = ORDER_W_DEF,
  parameter int DEPTH   = 8,
  localparam int REC_W_L = rec_width(XLEN, ORDER_W),
  localparam int LVL_W   = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NRET-1:0]         in_valid,
  input  logic [NRET*REC_W_L-1:0] in_rec,
  output logic                    out_valid,
  output logic [REC_W_L-1:0]      out_rec,
  output logic [ORDER_W-1:0]      out_order,
  output logic [LVL_W-1:0]        level,
  output logic                    err_window,
  output logic                    err_dup
);

  localparam int                 C_IDX_W     = $clog2(DEPTH);
  localparam int                 C_ORDER_LSB = REC_W_L - ORDER_W;
  localparam logic [ORDER_W:0]   C_DEPTH_V   = (ORDER_W + 1)'(DEPTH);

  logic [ORDER_W-1:0] r_next_order;
  logic               r_out_valid;
  logic [REC_W_L-1:0] r_out_rec;
  logic [ORDER_W-1:0] r_out_order;
  logic [LVL_W-1:0]   r_level;
  logic               r_err_window;
  logic               r_err_dup;

  logic [DEPTH-1:0]   w_slot_valid;
  logic [REC_W_L-1:0] w_slot_data  [DEPTH];
  logic [DEPTH-1:0]   w_slot_wr;
  logic [REC_W_L-1:0] w_slot_wdata [DEPTH];
  logic [DEPTH-1:0]   w_slot_clr;

  logic [ORDER_W-1:0] w_order [NRET];
  logic [ORDER_W-1:0] w_dist  [NRET];
  logic [C_IDX_W-1:0] w_idx   [NRET];
  logic [NRET-1:0]    w_in_win;
  logic [NRET-1:0]    w_dup;
  logic [NRET-1:0]    w_accept;
  logic               w_window_hit;
  logic               w_dup_hit;
  logic [LVL_W-1:0]   w_wr_cnt;
  logic [C_IDX_W-1:0] w_head;
  logic               w_drain;

  // Window is checked first: a duplicate can only be reported for an in-window order.
  always_comb begin
    w_window_hit = 1'b0;
    w_dup_hit    = 1'b0;
    w_wr_cnt     = '0;
    for (int c = 0; c < NRET; c++) begin
      w_order[c]  = in_rec[c*REC_W_L + C_ORDER_LSB +: ORDER_W];
      w_dist[c]   = w_order[c] - r_next_order;
      w_idx[c]    = w_order[c][C_IDX_W-1:0];
      w_in_win[c] = ({1'b0, w_dist[c]} < C_DEPTH_V);
      w_dup[c]    = w_slot_valid[w_idx[c]];
      for (int k = 0; k < c; k++) begin
        if (in_valid[k] && (w_order[k] == w_order[c]))
          w_dup[c] = 1'b1;
      end
      w_accept[c]  = in_valid[c] && w_in_win[c] && !w_dup[c];
      w_window_hit = w_window_hit | (in_valid[c] && !w_in_win[c]);
      w_dup_hit    = w_dup_hit | (in_valid[c] && w_in_win[c] && w_dup[c]);
      w_wr_cnt     = w_wr_cnt + LVL_W'(w_accept[c]);
    end
  end

  assign w_head  = r_next_order[C_IDX_W-1:0];
  assign w_drain = w_slot_valid[w_head];

  // Accepted channels never collide on a slot: equal index within the window means equal order.
  always_comb begin
    for (int s = 0; s < DEPTH; s++) begin
      w_slot_wr[s]    = 1'b0;
      w_slot_wdata[s] = '0;
      w_slot_clr[s]   = w_drain && (w_head == C_IDX_W'(s));
      for (int c = 0; c < NRET; c++) begin
        if (w_accept[c] && (w_idx[c] == C_IDX_W'(s))) begin
          w_slot_wr[s]    = 1'b1;
          w_slot_wdata[s] = in_rec[c*REC_W_L +: REC_W_L];
        end
      end
    end
  end

  generate
    for (genvar s = 0; s < DEPTH; s++) begin : g_slot
      rvfi_reorder_slot #(
        .REC_W (REC_W_L)
      ) u_slot (
        .clk     (clk),
        .resetn  (resetn),
        .wr_en   (w_slot_wr[s]),
        .wr_data (w_slot_wdata[s]),
        .clr     (w_slot_clr[s]),
        .valid   (w_slot_valid[s]),
        .data    (w_slot_data[s])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_next_order <= '0;
      r_out_valid  <= 1'b0;
      r_out_rec    <= '0;
      r_out_order  <= '0;
      r_level      <= '0;
      r_err_window <= 1'b0;
      r_err_dup    <= 1'b0;
    end else begin
      r_out_valid <= w_drain;
      if (w_drain) begin
        r_out_rec    <= w_slot_data[w_head];
        r_out_order  <= r_next_order;
        r_next_order <= r_next_order + 1'b1;
      end
      r_level <= r_level + w_wr_cnt - LVL_W'(w_drain);
      if (w_window_hit)
        r_err_window <= 1'b1;
      if (w_dup_hit)
        r_err_dup <= 1'b1;
    end
  end

`ifdef RVFI_REORDER_ASSERT_EN
  always @(posedge clk) begin
    if (resetn) begin
      assert (!r_err_window && !r_err_dup);
      assert (r_level <= LVL_W'(DEPTH));
    end
  end
`endif

  assign out_valid  = r_out_valid;
  assign out_rec    = r_out_rec;
  assign out_order  = r_out_order;
  assign level      = r_level;
  assign err_window = r_err_window;
  assign err_dup    = r_err_dup;

endmodule
`default_nettype wire

// File: tb/tb_rvfi_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rvfi_reorder_buffer
// Purpose  : Directed table-driven bench for rvfi_reorder_buffer.
// Revision : 1.0
// ============================================================================
module tb_rvfi_reorder_buffer;
  import rvfi_reorder_pkg::*;

  localparam int NRET = 2;
  localparam int RW   = 184;

  logic            clk = 1'b0;
  logic            resetn;
  logic [NRET-1:0] in_valid;
  logic [NRET*RW-1:0] in_rec;
  logic            out_valid;
  logic [RW-1:0]   out_rec;
  logic [7:0]      out_order;
  logic [3:0]      level;
  logic            err_window;
  logic            err_dup;

  int n_checks = 0;
  int n_pass   = 0;

  rvfi_reorder_buffer #(
    .NRET    (2),
    .XLEN    (32),
    .ORDER_W (8),
    .DEPTH   (8)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_rec     (in_rec),
    .out_valid  (out_valid),
    .out_rec    (out_rec),
    .out_order  (out_order),
    .level      (level),
    .err_window (err_window),
    .err_dup    (err_dup)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rstn;
    bit         v0;
    logic [7:0] o0;
    bit         v1;
    logic [7:0] o1;
    bit         ev;
    logic [7:0] eo;
    int         lvl;
    bit         ew;
    bit         ed;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [RW-1:0] mk_rec(input logic [7:0] o);
    rvfi_rec_t r;
    r.order    = o;
    r.insn     = {17'h0, o[4:0], 3'b000, 7'h13};
    r.rs1_addr = o[4:0];
    r.rs2_addr = ~o[4:0];
    r.rd_addr  = o[4:0] ^ 5'h3;
    r.pc       = 32'h8000_0000 + {22'h0, o, 2'b00};
    r.rdata    = {4{o}};
    r.wdata    = ~r.pc;
    r.trap     = o[0];
    r.mem_addr = {21'h0, o, 3'b000};
    return r;
  endfunction

  task automatic add(input bit rstn, input bit v0, input logic [7:0] o0,
                     input bit v1, input logic [7:0] o1, input bit ev,
                     input logic [7:0] eo, input int lvl, input bit ew, input bit ed);
    vec_t v;
    v.rstn = rstn; v.v0 = v0; v.o0 = o0; v.v1 = v1; v.o1 = o1;
    v.ev = ev; v.eo = eo; v.lvl = lvl; v.ew = ew; v.ed = ed;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_state(input string nm, input bit ev, input logic [7:0] eo,
                           input int lvl, input bit ew, input bit ed);
    chk({nm, ".out_valid"}, 64'(out_valid), 64'(ev));
    chk({nm, ".level"}, 64'(level), 64'(lvl));
    chk({nm, ".err_window"}, 64'(err_window), 64'(ew));
    chk({nm, ".err_dup"}, 64'(err_dup), 64'(ed));
    if (ev) begin
      chk({nm, ".out_order"}, 64'(out_order), 64'(eo));
      n_checks++;
      if (out_rec === mk_rec(eo)) n_pass++;
      else $display("FAIL %s.out_rec: got %h expected %h", nm, out_rec, mk_rec(eo));
    end
  endtask

  task automatic step(input bit rstn, input bit v0, input logic [7:0] o0,
                      input bit v1, input logic [7:0] o1);
    resetn   = rstn;
    in_valid = {v1, v0};
    in_rec   = {mk_rec(o1), mk_rec(o0)};
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn   = 1'b0;
    in_valid = '0;
    in_rec   = '0;
    @(posedge clk);
    #1;
    chk("reset.out_valid", 64'(out_valid), 64'd0);
    chk("reset.out_order", 64'(out_order), 64'd0);
    chk("reset.out_rec", 64'(out_rec[63:0]), 64'd0);
    chk("reset.level", 64'(level), 64'd0);
    chk("reset.errs", 64'({err_window, err_dup}), 64'd0);

    // in-order pair
    add(1, 1, 0, 1, 1,   0, 0, 2, 0, 0);
    add(1, 0, 0, 0, 0,   1, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0,   1, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    // reverse arrival
    add(0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    add(1, 1, 3, 0, 0,   0, 0, 1, 0, 0);
    add(1, 1, 2, 0, 0,   0, 0, 2, 0, 0);
    add(1, 1, 1, 0, 0,   0, 0, 3, 0, 0);
    add(1, 1, 0, 0, 0,   0, 0, 4, 0, 0);
    add(1, 0, 0, 0, 0,   1, 0, 3, 0, 0);
    add(1, 0, 0, 0, 0,   1, 1, 2, 0, 0);
    add(1, 0, 0, 0, 0,   1, 2, 1, 0, 0);
    add(1, 0, 0, 0, 0,   1, 3, 0, 0, 0);
    add(1, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    // window boundary
    add(0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    add(1, 1, 8, 0, 0,   0, 0, 0, 1, 0);
    add(1, 1, 7, 0, 0,   0, 0, 1, 1, 0);
    add(1, 0, 0, 0, 0,   0, 0, 1, 1, 0);
    // duplicate on two channels
    add(0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    add(1, 1, 5, 1, 5,   0, 0, 1, 0, 1);
    add(1, 1, 0, 1, 1,   0, 0, 3, 0, 1);
    add(1, 1, 2, 1, 3,   1, 0, 4, 0, 1);
    add(1, 1, 4, 0, 0,   1, 1, 4, 0, 1);
    add(1, 0, 0, 0, 0,   1, 2, 3, 0, 1);
    add(1, 0, 0, 0, 0,   1, 3, 2, 0, 1);
    add(1, 0, 0, 0, 0,   1, 4, 1, 0, 1);
    add(1, 0, 0, 0, 0,   1, 5, 0, 0, 1);
    add(1, 0, 0, 0, 0,   0, 0, 0, 0, 1);
    // reset mid-operation
    add(0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    add(1, 1, 1, 1, 2,   0, 0, 2, 0, 0);
    add(1, 1, 3, 1, 4,   0, 0, 4, 0, 0);
    add(1, 1, 20, 0, 0,  0, 0, 4, 1, 0);
    add(0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0,   0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0,   1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0,   0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rstn, vecs[i].v0, vecs[i].o0, vecs[i].v1, vecs[i].o1);
      chk_state($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eo, vecs[i].lvl,
                vecs[i].ew, vecs[i].ed);
    end

    // wrap: advance next_order to 254, then deliver 1,0,255,254
    step(0, 0, 0, 0, 0);
    for (int k = 0; k < 254; k++)
      step(1, 1, 8'(k), 0, 0);
    step(1, 0, 0, 0, 0);
    chk_state("wrap.pre_last", 1, 253, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk_state("wrap.pre_idle", 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    chk_state("wrap.in1", 0, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    chk_state("wrap.in0", 0, 0, 2, 0, 0);
    step(1, 1, 255, 0, 0);
    chk_state("wrap.in255", 0, 0, 3, 0, 0);
    step(1, 1, 254, 0, 0);
    chk_state("wrap.in254", 0, 0, 4, 0, 0);
    step(1, 0, 0, 0, 0);
    chk_state("wrap.out254", 1, 254, 3, 0, 0);
    step(1, 0, 0, 0, 0);
    chk_state("wrap.out255", 1, 255, 2, 0, 0);
    step(1, 0, 0, 0, 0);
    chk_state("wrap.out0", 1, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    chk_state("wrap.out1", 1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk_state("wrap.idle", 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
